// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FIPS-197 S-box tables and SubBytes FSM states
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sb_state_t;

    // Byte 0x00 sits in the most significant byte of each table
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        sbox_f = SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox_f(input logic [7:0] b);
        inv_sbox_f = INV_SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// rtl/sub_bytes_engine_if.sv - block-in / block-out handshake bundle for the SubBytes engine
interface sub_bytes_engine_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_data;
    logic                   in_inv;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sbox_lane.sv
// rtl/sbox_lane.sv - single-byte combinational S-box; forward table only built with SUBBYTES_FWD_EN
module sbox_lane
    import aes_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);

`ifdef SUBBYTES_FWD_EN
    assign dout = inv ? inv_sbox_f(din) : sbox_f(din);
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign dout       = inv_sbox_f(din);
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - LANES-wide time-multiplexed SubBytes over a 128-bit state
// Optional SUBBYTES_FWD_EN adds the forward table and the per-block in_inv mode flag.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sub_bytes_engine_if.slave   bus
);

    localparam int BEATS = AES_NUM_BYTES / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_t state, next_state;

    // Element 15-k holds state byte k, so the packed array lines up bit-for-bit with in_data
    logic [AES_NUM_BYTES-1:0][7:0] work;
    logic [AES_NUM_BYTES-1:0][7:0] next_work;
    logic [CNT_W-1:0]              cnt;
    logic                          accept;
    logic                          lane_inv;
    logic                          last_beat;

    logic [3:0] lane_idx [LANES];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

`ifdef SUBBYTES_FWD_EN
    logic mode;
    assign lane_inv = mode;
`else
    logic unused_inv;
    assign unused_inv = bus.in_inv;
    assign lane_inv   = 1'b1;
`endif

    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        next_state   = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        accept     = 1'b1;
                        next_state = BUSY;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt) * LANES + l);
            lane_in[l]  = work[~lane_idx[l]];
        end
    end

    // Kept separate from the lane-input mux so the lane feedback is not seen as a loop
    always_comb begin
        next_work = work;
        for (int l = 0; l < LANES; l++) begin
            next_work[~lane_idx[l]] = lane_out[l];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane u_lane (
            .inv  (lane_inv),
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
`ifdef SUBBYTES_FWD_EN
            mode  <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                work <= bus.in_data;
                cnt  <= '0;
`ifdef SUBBYTES_FWD_EN
                mode <= bus.in_inv;
`endif
            end else if (state == BUSY) begin
                work <= next_work;
                cnt  <= last_beat ? '0 : cnt + 1'b1;
            end
        end
    end

    assign bus.out_data = work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - self-checking bench for sub_bytes_engine against a GF(2^8) S-box model
module tb_sub_bytes_engine;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [7:0] ref_sbox [256];
    logic [7:0] ref_inv  [256];

    sub_bytes_engine_if bus ();

    sub_bytes_engine #(.LANES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic         sw_valid;
    logic [127:0] sw_data;
    logic         sw_inv;
    logic         sw_ready;
    logic [4:0]   sw_ov;
    logic [4:0]   sw_rdy;
    logic [127:0] sw_od [5];

    for (genvar g = 0; g < 5; g++) begin : g_sw
        sub_bytes_engine_if sw_bus ();
        assign sw_bus.in_valid  = sw_valid;
        assign sw_bus.in_data   = sw_data;
        assign sw_bus.in_inv    = sw_inv;
        assign sw_bus.out_ready = sw_ready;
        assign sw_ov[g]  = sw_bus.out_valid;
        assign sw_rdy[g] = sw_bus.in_ready;
        assign sw_od[g]  = sw_bus.out_data;
        sub_bytes_engine #(.LANES(1 << g)) u_sw (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sw_bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] s, r;
        s = b; r = b;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] o;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = d[127-8*k -: 8];
            o[127-8*k -: 8] = inv ? ref_inv[b] : ref_sbox[b];
        end
        return o;
    endfunction

    function automatic logic [127:0] exp_blk(input logic [127:0] d, input logic inv);
`ifdef SUBBYTES_FWD_EN
        return model(d, inv);
`else
        return model(d, 1'b1 | inv);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen
    task automatic send(input logic [127:0] d, input logic inv, output int lat);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", 128'(n < 50), 128'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = rnd128();
        bus.in_inv   = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [127:0] d, e, held;
        logic         inv, saw_valid;
        int           sw_lat [5];
        logic [127:0] sw_got [5];
        logic [4:0]   seen;

        vectors = 0;
        miscompares = 0;
        for (int x = 0; x < 256; x++) ref_sbox[x] = affine(ginv(8'(x)));
        for (int x = 0; x < 256; x++) ref_inv[ref_sbox[x]] = 8'(x);

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_inv = 1'b0; bus.out_ready = 1'b0;
        sw_valid = 1'b0; sw_data = '0; sw_inv = 1'b1; sw_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data", bus.out_data, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("post_rst_out_valid", 128'(bus.out_valid), 128'd0);

        send(128'd0, 1'b1, lat);
        chk("inv_zero_lat", 128'(lat), 128'd4);
        chk("inv_zero_data", bus.out_data, {16{8'h52}});
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", bus.out_data, held);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
        end

        d = rnd128();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_inv    = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        chk("b2b_busy", 128'(bus.out_valid), 128'd0);
        bus.in_valid = 1'b0;
        bus.in_data  = rnd128();
        bus.out_ready = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat", 128'(lat), 128'd4);
        chk("b2b_data", bus.out_data, exp_blk(d, 1'b1));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_idle_valid", 128'(bus.out_valid), 128'd0);
        chk("b2b_idle_ready", 128'(bus.in_ready), 128'd1);
        bus.out_ready = 1'b0;

        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, lat);
        chk("fips_fwd_lat", 128'(lat), 128'd4);
`ifdef SUBBYTES_FWD_EN
        chk("fips_fwd_data", bus.out_data, 128'hd42711aee0bf98f1b8b45de51e415230);
`else
        chk("fips_inv_forced", bus.out_data, model(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1));
`endif
        drain();
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, lat);
        chk("fips_inv_data", bus.out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        drain();

        for (int i = 0; i < 16; i++) begin
            d   = rnd128();
            inv = 1'($urandom_range(0, 1));
            e   = exp_blk(d, inv);
            send(d, inv, lat);
            chk("rand_lat", 128'(lat), 128'd4);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rand_data", bus.out_data, e);
            drain();
            chk("rand_release", 128'(bus.out_valid), 128'd0);
        end

        bus.in_valid = 1'b1;
        bus.in_data  = rnd128();
        bus.in_inv   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_data", bus.out_data, 128'd0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | bus.out_valid;
        end
        chk("midrst_no_valid", 128'(saw_valid), 128'd0);
        send({16{8'h63}}, 1'b1, lat);
        chk("midrst_fresh_lat", 128'(lat), 128'd4);
        chk("midrst_fresh_data", bus.out_data, 128'd0);
        drain();

        for (int v = 0; v < 2; v++) begin
            d = (v == 0) ? 128'hd42711aee0bf98f1b8b45de51e415230 : rnd128();
            chk("sweep_ready", 128'(sw_rdy), 128'h1f);
            sw_data  = d;
            sw_inv   = 1'b1;
            sw_valid = 1'b1;
            @(negedge clk);
            sw_valid = 1'b0;
            sw_data  = rnd128();
            seen = '0;
            for (int g = 0; g < 5; g++) begin
                sw_lat[g] = -1;
                sw_got[g] = '0;
            end
            for (int t = 0; t < 24; t++) begin
                for (int g = 0; g < 5; g++) begin
                    if (sw_ov[g] && !seen[g]) begin
                        seen[g]   = 1'b1;
                        sw_lat[g] = t;
                        sw_got[g] = sw_od[g];
                    end
                end
                @(negedge clk);
            end
            for (int g = 0; g < 5; g++) begin
                chk($sformatf("sweep_lat_lanes%0d", 1 << g), 128'(sw_lat[g]), 128'(16 >> g));
                chk($sformatf("sweep_data_lanes%0d", 1 << g), sw_got[g], model(d, 1'b1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Parametrised, handshaked SubBytes unit for the AES datapath that applies either the inverse or the forward S-box to a 128-bit state. It time-multiplexes `LANES` S-box instances over the 16 state bytes, trading area for latency. It sits between InvShiftRows and AddRoundKey in the iterative decryptor, and optionally serves the encryptor too.

## Interface
- `LANES`, 4: S-box lanes per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `in_valid`  input  1: `in_data`/`in_inv` valid.
- `in_ready`  output  1: engine accepts a block this cycle.
- `in_data`  input  128: state; byte k = `in_data[127-8k -: 8]`, k=0..15.
- `in_inv`  input  1: 1 = inverse S-box, 0 = forward S-box; sampled at accept.
- `out_valid`  output  1: `out_data` holds a finished block.
- `out_ready`  input  1: downstream accepts `out_data`.
- `out_data`  output  128: substituted state, same byte order as `in_data`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch `in_data` into the working register, latch `in_inv` into the mode flag, clear the beat counter, and go to BUSY.
- BUSY: each cycle substitutes bytes `cnt*LANES` .. `cnt*LANES+LANES-1` in place; `cnt` increments. After beat `BEATS-1` (BEATS = 16/LANES), go to DONE.
- The counter is `$clog2(BEATS)` bits wide, minimum 1 bit. With `LANES`=16 there is exactly one BUSY cycle.
- DONE: `out_valid`=1 and `out_data` is the working register. On `out_ready`, leave DONE.
  - If `in_valid` is also high, the new block is accepted in the same cycle and the FSM goes to BUSY.
  - Otherwise the FSM goes to IDLE.
- `in_ready` = IDLE | (DONE & `out_ready`).
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `in_data` and `in_inv` are sampled only at accept; later changes are ignored.
- Asserting `rst_n` low mid-block aborts the block. The partial result is discarded and never presented.

## Timing
- Reset values: FSM = IDLE, `in_ready`=1, `out_valid`=0, `out_data`=128'h0, `cnt`=0, mode=0.
- Latency: accept at edge N gives `out_valid`=1 after edge N+BEATS.
  - `LANES`=4: 4 cycles.
  - `LANES`=16: 1 cycle.
- Throughput: one block per BEATS+1 cycles when `out_ready` is held high, due to back-to-back accept from DONE.
- No combinational path from `in_valid` or `in_data` to any output.
- `in_ready` depends combinationally on `out_ready` only.

## Configuration
- `SUBBYTES_FWD_EN` defined:
  - each lane instantiates both the forward and the inverse table;
  - `in_inv` selects the table per block.
- `SUBBYTES_FWD_EN` undefined:
  - only the inverse table is built;
  - `in_inv` is ignored and every block uses the inverse S-box;
  - mode flag is removed;
  - ports are unchanged.

## Structure
- Shared package `aes_pkg`:
  - constants `AES_STATE_W`=128 and `AES_NUM_BYTES`=16;
  - functions `sbox_f(byte)` and `inv_sbox_f(byte)`, holding the FIPS-197 tables;
  - FSM state enum `sb_state_t`.
- One sub-module `sbox_lane`: a single-byte combinational substitution with an `inv` select. It is instantiated `LANES` times, and the byte mux/demux is indexed by `cnt`.

## Test plan
- Reset: hold `rst_n`=0, then release -> `in_ready`=1, `out_valid`=0, `out_data`=0.
- Inverse, all-zero input: `LANES`=4, `in_inv`=1, `in_data`=0 -> after 4 cycles, `out_valid`=1 and `out_data`=16 bytes of 0x52.
- Forward, FIPS-197 vector (`SUBBYTES_FWD_EN` defined): `in_inv`=0, `in_data`=193de3bea0f4e22b9ac68d2ae9f84808 -> `out_data`=d42711aee0bf98f1b8b45de51e415230.
  - Feed that result back with `in_inv`=1 -> original 193de3be... returned.
- Back-pressure and back-to-back: hold `out_ready`=0 for 5 cycles in DONE -> `out_data` stable and `in_ready`=0. Then set `out_ready`=1 with `in_valid`=1 -> output accepted and next block accepted in the same cycle.
- Mid-block reset: pulse `rst_n` low during the 2nd BUSY beat -> `out_valid` is never asserted for that block, and a fresh block of 0x63 bytes with `in_inv`=1 yields all 0x00.
- Lane sweep: repeat the inverse vector for `LANES`=1, 2, 8, 16 -> identical `out_data`, with latency of 16, 8, 2 and 1 cycles respectively.
